// File: rtl/eeprom_pkg.sv
// Shared definitions for the serial EEPROM bus responder: state encodings,
// default geometry and control-byte field positions.
package eeprom_pkg;

    localparam logic [3:0] DEV_TYPE_DEF = 4'b1010;
    localparam int         ADDR_W_DEF   = 11;
    localparam int         BYTE_W       = 8;
    localparam int         RW_BIT       = 0;

    typedef enum logic [9:0] {
        S_IDLE      = 10'b00_0000_0001,
        S_CTRL      = 10'b00_0000_0010,
        S_CTRL_ACK  = 10'b00_0000_0100,
        S_ADDR      = 10'b00_0000_1000,
        S_ADDR_ACK  = 10'b00_0001_0000,
        S_WDATA     = 10'b00_0010_0000,
        S_WDATA_ACK = 10'b00_0100_0000,
        S_RDATA     = 10'b00_1000_0000,
        S_RDATA_ACK = 10'b01_0000_0000,
        S_IGNORE    = 10'b10_0000_0000
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and derives the bus event strobes
// (SCL edges, START, STOP) from the synchronised levels.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic scl,
    input  logic sda,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_pipe_reg;
    logic [SYNC_STAGES-1:0] sda_pipe_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic scl_in;
            logic sda_in;
            if (gi == 0) begin : g_first
                assign scl_in = scl;
                assign sda_in = sda;
            end else begin : g_next
                assign scl_in = scl_pipe_reg[gi-1];
                assign sda_in = sda_pipe_reg[gi-1];
            end
            // Idle bus level is high, so reset to 1 to avoid phantom edges.
            always_ff @(posedge clk) begin
                if (srst) begin
                    scl_pipe_reg[gi] <= 1'b1;
                    sda_pipe_reg[gi] <= 1'b1;
                end else begin
                    scl_pipe_reg[gi] <= scl_in;
                    sda_pipe_reg[gi] <= sda_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_sync;
        end
    end

    assign scl_s    = scl_pipe_reg[SYNC_STAGES-1];
    assign sda_sync = sda_pipe_reg[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_reg;
    assign scl_fall = ~scl_s & scl_prev_reg;
    assign start    = scl_s & scl_prev_reg & sda_prev_reg & ~sda_sync;
    assign stop     = scl_s & scl_prev_reg & ~sda_prev_reg & sda_sync;

endmodule

// File: rtl/eeprom_slave_rsp.sv
// Two-wire serial EEPROM responder backed by a 2**ADDR_W x 8 array.
// Optional build macro WRITE_PROTECT_EN adds the WP input (write protect).
module eeprom_slave_rsp
    import eeprom_pkg::*;
#(
    parameter logic [3:0] DEV_TYPE    = DEV_TYPE_DEF,
    parameter int         ADDR_W      = ADDR_W_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
`ifdef WRITE_PROTECT_EN
    input  logic WP,
`endif
    output logic BUSY,
    output logic WR_DONE
);
    localparam int                HI_W    = ADDR_W - BYTE_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              sda_sync, scl_rise, scl_fall, start_evt, stop_evt;
    logic              wp_block;
    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [2:0]        bit_cnt_reg;
    logic [BYTE_W-2:0] shift_reg;
    logic [BYTE_W-1:0] rx_byte, tx_reg, rd_data_reg, wdata_reg;
    logic              rw_reg, ack_drv_reg, load_pend_reg, sda_low_reg;
    logic              busy_reg, wr_done_reg, mem_we_reg;
    logic              byte_done;
    logic [BYTE_W-1:0] mem [0:(1<<ADDR_W)-1];

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (CLK),
        .srst     (RESET),
        .scl      (SCL),
        .sda      (SDA),
        .sda_sync (sda_sync),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_evt),
        .stop     (stop_evt)
    );

`ifdef WRITE_PROTECT_EN
    assign wp_block = WP;
`else
    assign wp_block = 1'b0;
`endif

    assign rx_byte   = {shift_reg, sda_sync};
    assign byte_done = scl_rise && (bit_cnt_reg == 3'd7);
    assign SDA       = sda_low_reg ? 1'b0 : 1'bz;
    assign BUSY      = busy_reg;
    assign WR_DONE   = wr_done_reg;

    // The read port tracks the pointer continuously, so the next byte is
    // always ready long before the SCL fall that starts driving it.
    always_ff @(posedge CLK) begin
        if (mem_we_reg)
            mem[ptr_reg] <= wdata_reg;
        rd_data_reg <= mem[ptr_reg];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tx_reg        <= '0;
            wdata_reg     <= '0;
            rw_reg        <= 1'b0;
            ack_drv_reg   <= 1'b0;
            load_pend_reg <= 1'b0;
            sda_low_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            wr_done_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
        end else begin
            wr_done_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            if (stop_evt) begin
                state_reg     <= S_IDLE;
                bit_cnt_reg   <= '0;
                ack_drv_reg   <= 1'b0;
                load_pend_reg <= 1'b0;
                sda_low_reg   <= 1'b0;
                busy_reg      <= 1'b0;
            end else if (start_evt) begin
                state_reg     <= S_CTRL;
                bit_cnt_reg   <= '0;
                ack_drv_reg   <= 1'b0;
                load_pend_reg <= 1'b0;
                sda_low_reg   <= 1'b0;
            end else begin
                if (scl_rise && (state_reg == S_CTRL || state_reg == S_ADDR ||
                                 state_reg == S_WDATA || state_reg == S_RDATA)) begin
                    shift_reg   <= rx_byte[BYTE_W-2:0];
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                case (state_reg)
                    S_CTRL: if (byte_done) begin
                        if (rx_byte[7:4] == DEV_TYPE) begin
                            ptr_reg[ADDR_W-1:BYTE_W] <= rx_byte[RW_BIT+1 +: HI_W];
                            rw_reg    <= rx_byte[RW_BIT];
                            busy_reg  <= 1'b1;
                            state_reg <= S_CTRL_ACK;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= S_IGNORE;
                        end
                    end
                    S_ADDR: if (byte_done) begin
                        ptr_reg[BYTE_W-1:0] <= rx_byte;
                        state_reg           <= S_ADDR_ACK;
                    end
                    S_WDATA: if (byte_done) begin
                        if (wp_block) begin
                            state_reg <= S_IGNORE;
                        end else begin
                            mem_we_reg  <= 1'b1;
                            wdata_reg   <= rx_byte;
                            wr_done_reg <= 1'b1;
                            state_reg   <= S_WDATA_ACK;
                        end
                    end
                    // First fall after the byte drives ACK, the next one ends the slot.
                    S_CTRL_ACK, S_ADDR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (!ack_drv_reg) begin
                            sda_low_reg <= 1'b1;
                            ack_drv_reg <= 1'b1;
                        end else begin
                            ack_drv_reg <= 1'b0;
                            sda_low_reg <= 1'b0;
                            if (state_reg == S_CTRL_ACK) begin
                                if (rw_reg) begin
                                    tx_reg      <= {rd_data_reg[BYTE_W-2:0], 1'b1};
                                    sda_low_reg <= ~rd_data_reg[BYTE_W-1];
                                    state_reg   <= S_RDATA;
                                end else begin
                                    state_reg <= S_ADDR;
                                end
                            end else if (state_reg == S_ADDR_ACK) begin
                                state_reg <= S_WDATA;
                            end else begin
                                ptr_reg   <= ptr_reg + PTR_ONE;
                                state_reg <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (byte_done)
                            state_reg <= S_RDATA_ACK;
                        if (scl_fall) begin
                            if (load_pend_reg) begin
                                tx_reg        <= {rd_data_reg[BYTE_W-2:0], 1'b1};
                                sda_low_reg   <= ~rd_data_reg[BYTE_W-1];
                                load_pend_reg <= 1'b0;
                            end else begin
                                tx_reg      <= {tx_reg[BYTE_W-2:0], 1'b1};
                                sda_low_reg <= ~tx_reg[BYTE_W-1];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_fall)
                            sda_low_reg <= 1'b0;
                        if (scl_rise) begin
                            ptr_reg <= ptr_reg + PTR_ONE;
                            if (sda_sync) begin
                                state_reg <= S_IGNORE;
                            end else begin
                                load_pend_reg <= 1'b1;
                                state_reg     <= S_RDATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
